// File: rtl/vram_pkg.sv
// ---------------------------------------------------------------------------
// vram_pkg
// Shared definitions for the VRAM port arbiter:
//   - default address/data widths and wait-monitor settings
//   - slot_e : issue-slot state (what the RAM executes next cycle)
//   - tag_e  : return tag, which requester owns the read data in flight
//   - slot_to_tag : maps an executing slot to the tag of its read response
// ---------------------------------------------------------------------------
package vram_pkg;

  localparam int ADDR_W_DEF       = 11;
  localparam int DATA_W_DEF       = 8;
  localparam int WAIT_W_DEF       = 10;
  localparam int STARVE_LIMIT_DEF = 800;

  typedef enum logic [1:0] {
    SLOT_IDLE    = 2'd0,
    SLOT_DISP    = 2'd1,
    SLOT_HOST_RD = 2'd2,
    SLOT_HOST_WR = 2'd3
  } slot_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_HOST = 2'd2
  } tag_e;

  // Writes return nothing, so only read slots produce a tag.
  function automatic tag_e slot_to_tag(input slot_e s);
    tag_e t;
    case (s)
      SLOT_DISP:    t = TAG_DISP;
      SLOT_HOST_RD: t = TAG_HOST;
      default:      t = TAG_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/vram_wait_monitor.sv
// ---------------------------------------------------------------------------
// vram_wait_monitor
// Counts consecutive cycles the host is held off (host_valid && !host_ready),
// saturating at all-ones, and flags host_starved once the count reaches
// STARVE_LIMIT. The count clears on a handshake or when host_valid drops.
// Ports:
//   pixel_clk    in   clock
//   reset        in   synchronous, active-high
//   host_valid   in   host request
//   host_ready   in   host accepted this cycle
//   host_starved out  registered, equals (wait count >= STARVE_LIMIT)
// ---------------------------------------------------------------------------
module vram_wait_monitor #(
  parameter int WAIT_W       = 10,
  parameter int STARVE_LIMIT = 800
) (
  input  logic pixel_clk,
  input  logic reset,
  input  logic host_valid,
  input  logic host_ready,
  output logic host_starved
);

  localparam logic [WAIT_W-1:0] CNT_MAX = '1;
  // One extra bit so a limit equal to 2^WAIT_W is still representable.
  localparam logic [WAIT_W:0]   LIMIT   = (WAIT_W+1)'(STARVE_LIMIT);

  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              starved_q, starved_d;

  always_comb begin
    cnt_d = '0;
    if (host_valid && !host_ready) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
    // Compare against the next count so the flag tracks the counter
    // register exactly instead of lagging it by a cycle.
    starved_d = ({1'b0, cnt_d} >= LIMIT);
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      cnt_q     <= '0;
      starved_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      starved_q <= starved_d;
    end
  end

  assign host_starved = starved_q;

endmodule

// File: rtl/vram_port_arbiter.sv
// ---------------------------------------------------------------------------
// vram_port_arbiter
// Shares a single-port synchronous VRAM between the display fetch path
// (absolute priority, fixed 2-cycle read latency) and a host port.
//
// Host handshake: a transfer happens in any cycle where host_valid and
// host_ready are both 1. host_ready does not depend on host_valid; while
// host_valid=1 and host_ready=0 the host holds addr/we/wdata stable.
//
// Optional build macro VRAM_TEAR_FREE_EN: when defined, host writes are only
// accepted outside the active video area (video_enable=0); reads unaffected.
//
// Ports:
//   pixel_clk, reset                 clock, synchronous active-high reset
//   video_enable                     active-area flag
//   disp_req/disp_addr               display fetch request
//   disp_rvalid/disp_rdata           display read response (cycle C+2)
//   host_valid/we/addr/wdata         host request
//   host_ready                       host accepted this cycle (combinational)
//   host_rvalid/host_rdata           host read response (cycle C+2)
//   host_starved                     host waited >= STARVE_LIMIT cycles
//   mem_en/we/addr/wdata, mem_rdata  RAM macro interface
//   dbg_slot                         issue-slot state for observation
// ---------------------------------------------------------------------------
module vram_port_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int WAIT_W       = WAIT_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic              video_enable,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_starved,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output slot_e             dbg_slot
);

  slot_e             slot_q, slot_d;
  tag_e              tag_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              host_ready_c;
  logic              host_fire;

  // Arbitration: display wins outright; host takes every other slot.
  // Nothing is accepted while reset is held.
  always_comb begin
    host_ready_c = 1'b0;
    if (!reset && !disp_req) begin
`ifdef VRAM_TEAR_FREE_EN
      host_ready_c = !(host_we && video_enable);
`else
      host_ready_c = 1'b1;
`endif
    end
  end

`ifndef VRAM_TEAR_FREE_EN
  logic unused_video_enable;
  assign unused_video_enable = video_enable;
`endif

  assign host_ready = host_ready_c;
  assign host_fire  = host_valid && host_ready_c;

  // Next slot comes straight from this cycle's grant.
  always_comb begin
    slot_d      = SLOT_IDLE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (disp_req) begin
      slot_d     = SLOT_DISP;
      mem_addr_d = disp_addr;
    end else if (host_fire) begin
      slot_d     = host_we ? SLOT_HOST_WR : SLOT_HOST_RD;
      mem_addr_d = host_addr;
      if (host_we) begin
        mem_wdata_d = host_wdata;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      slot_q      <= SLOT_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_q       <= TAG_NONE;
    end else begin
      slot_q      <= slot_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      // The RAM executes slot_q now; its read data lands next cycle.
      tag_q       <= slot_to_tag(slot_q);
    end
  end

  // Output decode from registered state only.
  always_comb begin
    mem_en      = (slot_q != SLOT_IDLE);
    mem_we      = (slot_q == SLOT_HOST_WR);
    disp_rvalid = (tag_q == TAG_DISP);
    host_rvalid = (tag_q == TAG_HOST);
    disp_rdata  = disp_rvalid ? mem_rdata : '0;
    host_rdata  = host_rvalid ? mem_rdata : '0;
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_slot  = slot_q;

  vram_wait_monitor #(
    .WAIT_W      (WAIT_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_wait_monitor (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .host_valid  (host_valid),
    .host_ready  (host_ready_c),
    .host_starved(host_starved)
  );

endmodule
